// File: rtl/uart_rx_buffered_pkg.sv
// Shared constants for the buffered UART receiver: FSM encoding, oversampling
// and majority-vote sample positions, frame geometry.
package uart_rx_buffered_pkg;
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int SAMPLE_T0  = 7;
    localparam int SAMPLE_T1  = 8;
    localparam int SAMPLE_T2  = 9;
    localparam int DATA_BITS  = 8;
    localparam int BIT_W      = $clog2(DATA_BITS);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_rx_buffered_if.sv
// Consumer-side read stream of the receive FIFO.
// Handshake: rd_data is stable and meaningful whenever rd_valid=1; a byte is
// consumed on every rising clk edge where rd_valid && rd_ready; rd_ready while
// rd_valid=0 does nothing.
interface uart_rx_buffered_if;
    import uart_rx_buffered_pkg::*;

    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (output rd_data, output rd_valid, input rd_ready);
    modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// First-word fall-through synchronous FIFO with occupancy count and a
// one-cycle drop indication when a write hits a full FIFO without a pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   wr_drop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop, full;

    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FULL_COUNT);
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot the incoming byte needs.
    assign push     = wr_en && (!full || pop);
    assign wr_drop  = wr_en && full && !pop;
    assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
    assign count    = count_q;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with 16x oversampling, 2-of-3 majority bit decisions,
// framing-error/break handling and a FWFT receive FIFO.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    uart_rx_buffered_if.master          rd,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic [2:0]                  state_dbg
);
    localparam int OSDIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W = (OSDIV > 1) ? $clog2(OSDIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX = DIV_W'(OSDIV - 1);
    localparam logic [TICK_W-1:0] T0      = TICK_W'(SAMPLE_T0);
    localparam logic [TICK_W-1:0] T1      = TICK_W'(SAMPLE_T1);
    localparam logic [TICK_W-1:0] T2      = TICK_W'(SAMPLE_T2);
    localparam logic [TICK_W-1:0] T_LAST  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  B_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
    logic [2:0]           state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 push_q, push_d, frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic                 tick, maj, fifo_drop;

    always_comb begin
        rx_meta_d   = rx;
        rx_sync_d   = rx_meta_q;
        rx_prev_d   = rx_sync_q;
        state_d     = state_q;
        div_d       = div_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        samp_d      = samp_q;
        shreg_d     = shreg_q;
        push_d      = 1'b0;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q | fifo_drop;
        tick        = 1'b0;
        maj         = maj3(samp_q[0], samp_q[1], rx_sync_q);

        // The divider is held at zero while idle so bit timing is anchored
        // to the detected start edge.
        if (state_q == ST_IDLE) begin
            div_d      = '0;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            if (rx_prev_q && !rx_sync_q) begin
                state_d = ST_START;
            end
        end else begin
            tick  = (div_q == DIV_MAX);
            div_d = tick ? '0 : div_q + 1'b1;
        end

        if (tick) begin
            tick_cnt_d = tick_cnt_q + 1'b1;
            if (tick_cnt_q == T0) samp_d[0] = rx_sync_q;
            if (tick_cnt_q == T1) samp_d[1] = rx_sync_q;
            case (state_q)
                ST_START: begin
                    if (tick_cnt_q == T2 && maj) begin
                        state_d = ST_IDLE;
                    end else if (tick_cnt_q == T_LAST) begin
                        state_d = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == T2) begin
                        shreg_d = {maj, shreg_q[DATA_BITS-1:1]};
                    end
                    if (tick_cnt_q == T_LAST) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == B_LAST) state_d = ST_STOP;
                    end
                end
                ST_STOP: begin
                    // Decide at the last sample and re-arm early so a
                    // back-to-back start edge is not missed.
                    if (tick_cnt_q == T2) begin
                        if (maj) begin
                            push_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_BREAK;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (state_q == ST_BREAK && rx_sync_q) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q   <= 1'b1;
            rx_sync_q   <= 1'b1;
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            div_q       <= '0;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            samp_q      <= '0;
            shreg_q     <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_sync_q   <= rx_sync_d;
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            div_q       <= div_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            samp_q      <= samp_d;
            shreg_q     <= shreg_d;
            push_q      <= push_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (push_q),
        .wr_data  (shreg_q),
        .wr_drop  (fifo_drop),
        .rd_data  (rd.rd_data),
        .rd_valid (rd.rd_valid),
        .rd_ready (rd.rd_ready),
        .count    (fifo_count)
    );

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: table-driven single frames plus
// hand-written glitch, overrun, reset and full-FIFO sequences.
module tb_uart_rx_buffered;
    import uart_rx_buffered_pkg::*;

    // 9600 baud with a small divider keeps every frame at 640 clocks.
    localparam int BAUD     = 9600;
    localparam int CLK_FREQ = BAUD * 16 * 4;
    localparam int DEPTH    = 8;
    localparam int OSDIV    = 4;
    localparam int BIT_CLKS = 16 * OSDIV;

    typedef struct {
        logic [7:0]  data;
        logic        stop;
        logic [31:0] exp_fe;
        logic [31:0] exp_bytes;
    } vec_t;

    logic       clk, reset, rx;
    logic       frame_err, overrun;
    logic [3:0] fifo_count;
    logic [2:0] state_dbg;
    uart_rx_buffered_if rd_if();

    logic [7:0] exp_q[$];
    int checks, errors;
    int fe_cnt, fe_long, rx_cnt, valid_cyc;
    logic fe_prev;

    uart_rx_buffered #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rd         (rd_if),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_count (fifo_count),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] bits;
        bits = {stop_bit, data, 1'b0};
        for (int b = 0; b < 10; b++) begin
            rx = bits[b];
            tick_clks(BIT_CLKS);
        end
        rx = 1'b1;
    endtask

    task automatic wait_empty(input string name, input int limit);
        int n;
        n = 0;
        while (rd_if.rd_valid && n < limit) begin
            tick_clks(1);
            n++;
        end
        check(name, rd_if.rd_valid, 1'b0);
    endtask

    // Scoreboard: every accepted byte is compared against the expected queue.
    initial begin
        fe_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (frame_err) fe_cnt++;
                if (frame_err && fe_prev) fe_long++;
                fe_prev = frame_err;
                if (rd_if.rd_valid) valid_cyc++;
                if (rd_if.rd_valid && rd_if.rd_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL pop_unexpected got %02h required no data", rd_if.rd_data);
                    end else begin
                        logic [7:0] e;
                        e = exp_q.pop_front();
                        if (rd_if.rd_data !== e) begin
                            errors++;
                            $display("FAIL pop_data got %02h required %02h", rd_if.rd_data, e);
                        end
                        rx_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog got timeout required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        vec_t       vecs[6];
        int         fe0, rx0, v0, n;
        logic [7:0] c3_byte;

        vecs[0] = '{8'h41, 1'b1, 0, 1};
        vecs[1] = '{8'h00, 1'b1, 0, 1};
        vecs[2] = '{8'hFF, 1'b1, 0, 1};
        vecs[3] = '{8'h55, 1'b0, 1, 0};
        vecs[4] = '{8'hA5, 1'b1, 0, 1};
        vecs[5] = '{8'h3C, 1'b1, 0, 1};

        checks = 0; errors = 0;
        fe_cnt = 0; fe_long = 0; rx_cnt = 0; valid_cyc = 0;
        reset = 1'b1;
        rx = 1'b1;
        rd_if.rd_ready = 1'b0;
        tick_clks(3);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_count", fifo_count, 0);
        check("rst_valid", rd_if.rd_valid, 0);
        check("rst_data", rd_if.rd_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        reset = 1'b0;
        tick_clks(BIT_CLKS);

        // Single frames with the consumer always ready.
        rd_if.rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            fe0 = fe_cnt; rx0 = rx_cnt; v0 = valid_cyc;
            if (vecs[i].stop) exp_q.push_back(vecs[i].data);
            send_frame(vecs[i].data, vecs[i].stop);
            tick_clks(2 * BIT_CLKS);
            check($sformatf("vec%0d_frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
            check($sformatf("vec%0d_bytes", i), rx_cnt - rx0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_valid_cycles", i), valid_cyc - v0, vecs[i].exp_bytes);
            check($sformatf("vec%0d_state", i), state_dbg, ST_IDLE);
            check($sformatf("vec%0d_count", i), fifo_count, 0);
            check($sformatf("vec%0d_overrun", i), overrun, 0);
        end

        // Start-bit glitch of three ticks is rejected.
        fe0 = fe_cnt; rx0 = rx_cnt;
        rx = 1'b0;
        tick_clks(3 * OSDIV);
        check("glitch_enters_start", state_dbg, ST_START);
        rx = 1'b1;
        tick_clks(2 * BIT_CLKS);
        check("glitch_state", state_dbg, ST_IDLE);
        check("glitch_bytes", rx_cnt - rx0, 0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
        check("glitch_count", fifo_count, 0);

        // Nine back-to-back frames into an unread FIFO.
        rd_if.rd_ready = 1'b0;
        rx0 = rx_cnt;
        for (int i = 1; i <= 8; i++) begin
            exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        check("fill_count", fifo_count, 8);
        check("fill_overrun", overrun, 0);
        send_frame(8'h09, 1'b1);
        tick_clks(4);
        check("ovr_overrun", overrun, 1);
        check("ovr_count", fifo_count, 8);
        rd_if.rd_ready = 1'b1;
        wait_empty("ovr_drain", 64);
        check("ovr_drained_bytes", rx_cnt - rx0, 8);
        check("ovr_sticky", overrun, 1);
        check("ovr_count_empty", fifo_count, 0);

        // Reset in the middle of a data bit with two bytes queued.
        rd_if.rd_ready = 1'b0;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("pre_rst_count", fifo_count, 2);
        c3_byte = 8'hC3;
        rx = 1'b0;
        tick_clks(BIT_CLKS);
        for (int b = 0; b < 3; b++) begin
            rx = c3_byte[b];
            tick_clks(BIT_CLKS);
        end
        check("pre_rst_state", state_dbg, ST_DATA);
        reset = 1'b1;
        #1;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_valid", rd_if.rd_valid, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_state", state_dbg, ST_IDLE);
        check("mid_rst_data", rd_if.rd_data, 0);
        exp_q.delete();
        rx = 1'b1;
        tick_clks(2);
        reset = 1'b0;
        tick_clks(BIT_CLKS);
        rd_if.rd_ready = 1'b1;
        rx0 = rx_cnt;
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1);
        tick_clks(2 * BIT_CLKS);
        check("post_rst_bytes", rx_cnt - rx0, 1);
        check("post_rst_overrun", overrun, 0);

        // Full FIFO: pop coincides with the ninth push.
        rd_if.rd_ready = 1'b0;
        rx0 = rx_cnt;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(8'(8'h80 + i));
            send_frame(8'(8'h80 + i), 1'b1);
        end
        check("full_count", fifo_count, 8);
        exp_q.push_back(8'h88);
        n = 0;
        fork
            send_frame(8'h88, 1'b1);
            begin
                while (state_dbg != ST_STOP && n < 2000) begin
                    tick_clks(1);
                    n++;
                end
                while (state_dbg != ST_IDLE && n < 2000) begin
                    tick_clks(1);
                    n++;
                end
                check("full_push_seen", n < 2000, 1);
                rd_if.rd_ready = 1'b1;
                tick_clks(1);
                rd_if.rd_ready = 1'b0;
            end
        join
        tick_clks(2);
        check("full_same_clk_count", fifo_count, 8);
        check("full_same_clk_overrun", overrun, 0);
        rd_if.rd_ready = 1'b1;
        wait_empty("full_drain", 64);
        check("full_bytes", rx_cnt - rx0, 9);

        tick_clks(4);
        check("exp_queue_empty", exp_q.size(), 0);
        check("frame_err_width", fe_long, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_buffered.md
UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600, serial bit rate.
REQ-003 Parameter FIFO_DEPTH, default 8, receive FIFO entries (power of two, >=2).
REQ-004 Port clk  input  1  single clock; all logic rising-edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-007 Port rd_data  output  8  byte at FIFO head.
REQ-008 Port rd_valid  output  1  FIFO non-empty; rd_data valid.
REQ-009 Port rd_ready  input  1  consumer accepts head byte.
REQ-010 Port frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-011 Port overrun  output  1  sticky flag: byte dropped because FIFO full.
REQ-012 Port fifo_count  output  $clog2(FIFO_DEPTH)+1  occupied entries.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-014 Oversample tick SHALL pulse for one clk every OSDIV = CLK_FREQ/(BAUD_RATE*16) cycles (integer truncation; 325 at defaults); counter free-runs only while not IDLE and restarts at 0 on leaving IDLE.
REQ-015 FSM states: IDLE, START, DATA, STOP, BREAK.
REQ-016 IDLE -> START on synchronized rx high-to-low transition.
REQ-017 Each bit SHALL span 16 ticks; bit value = 2-of-3 majority of samples at ticks 7, 8, 9.
REQ-018 START: majority 1 -> IDLE (glitch rejected, nothing pushed); majority 0 -> DATA at tick 15.
REQ-019 DATA: 8 bits shifted LSB first; after bit 7 -> STOP.
REQ-020 STOP: majority 1 -> push byte, -> IDLE after tick 9 (early re-arm for back-to-back frames).
REQ-021 STOP: majority 0 -> frame_err high for exactly one clk, byte discarded, -> BREAK.
REQ-022 BREAK -> IDLE only once synchronized rx has been high for one clk.
REQ-023 Push occurs the clk after the stop-bit majority decision; rd_valid asserts the following clk when FIFO was empty.
REQ-024 FIFO SHALL be first-word fall-through: rd_data equals head whenever rd_valid=1; pop on rd_valid && rd_ready.
REQ-025 rd_ready while empty SHALL have no effect; fifo_count never underflows.
REQ-026 Push while full and no pop in same clk: byte dropped, overrun set to 1, FIFO contents unchanged.
REQ-027 Push and pop in same clk while full: both performed, count unchanged, overrun unaffected.
REQ-028 Push and pop in same clk otherwise: both performed, count unchanged.
REQ-029 Read/write pointers SHALL wrap modulo FIFO_DEPTH; count distinguishes full from empty.
REQ-030 overrun SHALL remain 1 until reset.

Reset
REQ-031 Reset asserted SHALL immediately force: FSM IDLE, synchronizer flops 1, tick/bit counters 0, pointers 0, fifo_count 0, rd_valid 0, rd_data 0, frame_err 0, overrun 0.
REQ-032 Reset mid-frame SHALL abandon the partial byte; after release, reception resumes at the next falling edge.
REQ-033 FIFO storage array need not be reset; rd_data SHALL read 0 while empty after reset.

Structure
REQ-034 Shared package SHALL hold the FSM state encoding, OVERSAMPLE=16, SAMPLE_TICKS {7,8,9}, DATA_BITS=8.
REQ-035 FIFO SHALL be a sub-module uart_sync_fifo (width 8, depth FIFO_DEPTH, FWFT, count output); serial front end stays in uart_rx_buffered.

Verification
REQ-036 Transmit 0x41 at 9600 baud, rd_ready=1 -> one rd_valid clk, rd_data=0x41, frame_err=0, overrun=0.
REQ-037 Send 0x01..0x09 back-to-back, rd_ready=0 -> fifo_count=8, overrun=1 after 9th stop bit; draining yields 0x01..0x08 in order.
REQ-038 Send 0x55 with stop bit driven 0 -> frame_err one-clk pulse, fifo_count unchanged; next frame 0xA5 received correctly once line returns high.
REQ-039 rx low for 3 bit-ticks (~975 clk) then high -> no push, FSM returns IDLE, frame_err=0.
REQ-040 Assert reset mid-DATA of 0xC3 with 2 bytes queued -> fifo_count=0, rd_valid=0, overrun=0; subsequent 0x3C received intact.
REQ-041 FIFO full (8 bytes) with rd_ready=1 held as 9th byte's push occurs -> no overrun, count stays 8, 9th byte read last.
